// File: rtl/rr_grant_arbiter_4_if.sv
// rr_grant_arbiter_4_if
// Request/grant bundle between the four requesters and the round-robin
// arbiter. The arbiter connects via the slave modport; the requester side
// (or a testbench) drives it through master.
interface rr_grant_arbiter_4_if;
  logic       en;           // arbiter enable
  logic [3:0] req;          // level-sensitive request, bit i = requester i
  logic [3:0] grant;        // registered one-hot grant
  logic [1:0] grant_idx;    // registered owner index (feeds decoder 'in')
  logic       grant_valid;  // registered grant-active flag (feeds decoder 'en')

  modport master (
    output en,
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid
  );

  modport slave (
    input  en,
    input  req,
    output grant,
    output grant_idx,
    output grant_valid
  );
endinterface

// File: rtl/rr_grant_arbiter_4.sv
// rr_grant_arbiter_4
// Four-requester round-robin arbiter in front of the 2-to-4 decode path.
// One owner at a time; the owner keeps the grant while it holds its request.
// On release the grant moves to the next round-robin winner on the same edge
// (no dead cycle), or drops to idle when nothing else is requesting.
// All outputs are registered.
//
// Optional feature: define RR_ARB_HOLD_TIMEOUT_EN to compile in a hold
// counter that force-rotates the grant after MAX_HOLD consecutive cycles
// when another requester is waiting. Without the macro MAX_HOLD only gets
// a range check and there is no preemption.
module rr_grant_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_grant_arbiter_4_if.slave   arb_bus
);

  // Reject out-of-range hold limits at elaboration time.
  if ((MAX_HOLD < 32'd2) || (MAX_HOLD > 32'd256)) begin : g_max_hold_range
    $error("rr_grant_arbiter_4: MAX_HOLD must be within 2..256");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // What the arbiter does at the coming edge.
  typedef enum logic [1:0] {
    ACT_CLEAR = 2'd0,   // no grant after the edge
    ACT_GRANT = 2'd1,   // (re)arbitrate and grant the round-robin winner
    ACT_HOLD  = 2'd2    // keep the current owner
  } act_t;

  // One-hot encoding of an owner index.
  function automatic logic [3:0] f_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // First asserted request scanning start, start+1, ... with 2-bit wrap.
  function automatic logic [1:0] f_rr_pick(input logic [3:0] req_v,
                                           input logic [1:0] start);
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = start + i[1:0];
      if (!found && req_v[cand]) begin
        pick  = cand;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;
  logic [3:0] r_grant;
  logic [3:0] w_grant_nxt;
  logic [1:0] r_grant_idx;
  logic [1:0] w_grant_idx_nxt;
  logic       r_grant_valid;
  logic       w_grant_valid_nxt;

  act_t       w_act;
  logic [1:0] w_winner;
  logic       w_any_req;
  logic       w_owner_req;
  logic       w_other_req;
  logic       w_timeout;

  // The pointer already sits one past the current owner, so the owner is
  // scanned last and therefore has the lowest priority on re-arbitration.
  assign w_winner    = f_rr_pick(arb_bus.req, r_ptr);
  assign w_any_req   = |arb_bus.req;
  assign w_owner_req = arb_bus.req[r_grant_idx];
  assign w_other_req = |(arb_bus.req & ~f_onehot(r_grant_idx));

`ifdef RR_ARB_HOLD_TIMEOUT_EN
  localparam int unsigned     CNT_W    = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 32'd1);

  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;

  // Counter at its limit: the owner has used its full hold window.
  assign w_timeout = (r_hold_cnt == CNT_LAST);

  // Hold counter: cleared on every new grant or idle, saturates at the limit.
  always_comb begin
    w_hold_cnt_nxt = r_hold_cnt;
    case (w_act)
      ACT_GRANT: w_hold_cnt_nxt = '0;
      ACT_HOLD: begin
        if (w_timeout) begin
          w_hold_cnt_nxt = r_hold_cnt;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
        end
      end
      ACT_CLEAR: w_hold_cnt_nxt = '0;
      default:   w_hold_cnt_nxt = '0;
    endcase
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end
`else
  // No hold limit: the owner keeps the grant until it releases.
  assign w_timeout = 1'b0;
`endif

  // Decide the action for this edge, then derive next state and outputs.
  always_comb begin
    w_act             = ACT_CLEAR;
    w_state_nxt       = ST_IDLE;
    w_ptr_nxt         = r_ptr;
    w_grant_idx_nxt   = r_grant_idx;
    w_grant_valid_nxt = 1'b0;
    w_grant_nxt       = 4'b0000;

    case (r_state)
      ST_IDLE: begin
        if (arb_bus.en && w_any_req) begin
          w_act = ACT_GRANT;
        end else begin
          w_act = ACT_CLEAR;
        end
      end
      ST_BUSY: begin
        if (!arb_bus.en) begin
          w_act = ACT_CLEAR;
        end else if (!w_owner_req) begin
          // Owner released; hand over immediately if anyone else waits.
          if (w_any_req) begin
            w_act = ACT_GRANT;
          end else begin
            w_act = ACT_CLEAR;
          end
        end else if (w_timeout && w_other_req) begin
          w_act = ACT_GRANT;
        end else begin
          w_act = ACT_HOLD;
        end
      end
      default: begin
        w_act = ACT_CLEAR;
      end
    endcase

    case (w_act)
      ACT_GRANT: begin
        w_state_nxt       = ST_BUSY;
        w_ptr_nxt         = w_winner + 2'd1;
        w_grant_idx_nxt   = w_winner;
        w_grant_valid_nxt = 1'b1;
        w_grant_nxt       = f_onehot(w_winner);
      end
      ACT_HOLD: begin
        w_state_nxt       = ST_BUSY;
        w_grant_valid_nxt = 1'b1;
        w_grant_nxt       = f_onehot(r_grant_idx);
      end
      ACT_CLEAR: begin
        w_state_nxt       = ST_IDLE;
        w_grant_valid_nxt = 1'b0;
        w_grant_nxt       = 4'b0000;
      end
      default: begin
        w_state_nxt       = ST_IDLE;
        w_grant_valid_nxt = 1'b0;
        w_grant_nxt       = 4'b0000;
      end
    endcase
  end

  // State, pointer and registered grant outputs; reset clears asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= 2'd0;
      r_grant       <= 4'b0000;
      r_grant_idx   <= 2'd0;
      r_grant_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_idx   <= w_grant_idx_nxt;
      r_grant_valid <= w_grant_valid_nxt;
    end
  end

  assign arb_bus.grant       = r_grant;
  assign arb_bus.grant_idx   = r_grant_idx;
  assign arb_bus.grant_valid = r_grant_valid;

endmodule

// File: tb/tb_rr_grant_arbiter_4.sv
// tb_rr_grant_arbiter_4
// Directed bench for rr_grant_arbiter_4. Each step drives en/req, pushes the
// expected post-edge outputs onto a scoreboard queue, and pops/compares them
// one time unit after the rising edge. Build with RR_ARB_HOLD_TIMEOUT_EN
// defined to exercise the hold-timeout rotation (MAX_HOLD = 4).
module tb_rr_grant_arbiter_4;
  localparam int unsigned MAX_HOLD = 4;

  typedef struct {
    logic       valid;
    logic [1:0] idx;
    logic [3:0] grant;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst_n;
  exp_t       sb_q[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  logic [1:0] last_idx = 2'b00;

  rr_grant_arbiter_4_if u_if ();

  rr_grant_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_bus (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs: grant_idx holds its previous value while invalid.
  task automatic push_exp(input logic v, input logic [1:0] idx, input string tag);
    exp_t x;
    if (v) last_idx = idx;
    else   last_idx = last_idx;
    x.valid = v;
    x.idx   = last_idx;
    x.grant = v ? (4'b0001 << idx) : 4'b0000;
    x.tag   = tag;
    sb_q.push_back(x);
  endtask

  task automatic check_out();
    exp_t x;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    x = sb_q.pop_front();
    n_assert++;
    assert (u_if.grant === x.grant) else begin
      n_fail++;
      $error("FAIL %s grant observed=%b expected=%b", x.tag, u_if.grant, x.grant);
    end
    n_assert++;
    assert (u_if.grant_valid === x.valid) else begin
      n_fail++;
      $error("FAIL %s grant_valid observed=%b expected=%b", x.tag, u_if.grant_valid, x.valid);
    end
    n_assert++;
    assert (u_if.grant_idx === x.idx) else begin
      n_fail++;
      $error("FAIL %s grant_idx observed=%0d expected=%0d", x.tag, u_if.grant_idx, x.idx);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] r, input logic v,
                      input logic [1:0] idx, input string tag);
    u_if.en  = e;
    u_if.req = r;
    push_exp(v, idx, tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Pulse reset between edges and check the outputs clear with no clock.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    last_idx = 2'b00;
    push_exp(1'b0, 2'd0, tag);
    #1;
    check_out();
  endtask

  initial begin
    logic [3:0] v_req;
    rst_n    = 1'b0;
    u_if.en  = 1'b0;
    u_if.req = 4'b0000;

    #2;
    push_exp(1'b0, 2'd0, "reset");
    check_out();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Enabled but nobody requesting: stays idle.
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0000, 1'b0, 2'd0, "idle");

    // Back-to-back rotation 0,1,2,3,0 with each owner dropping for one cycle.
    step(1'b1, 4'b1111, 1'b1, 2'd0, "rot_first");
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'b1111, 1'b1, 2'(k), "rot_hold");
      step(1'b1, 4'b1111, 1'b1, 2'(k), "rot_hold");
      v_req = 4'b1111 & ~(4'b0001 << k);
      step(1'b1, v_req, 1'b1, 2'((k + 1) % 4), "rot_handover");
    end
    step(1'b1, 4'b0000, 1'b0, 2'd0, "rot_idle");

    // Single request: 1-cycle latency, then release to idle (idx held).
    step(1'b1, 4'b0100, 1'b1, 2'd2, "single_grant");
    step(1'b1, 4'b0100, 1'b1, 2'd2, "single_hold");
    step(1'b1, 4'b0000, 1'b0, 2'd0, "single_release");

    // Owner 1, enable drops, re-enable with 0011: scan from ptr=2 wraps to 0.
    step(1'b1, 4'b0010, 1'b1, 2'd1, "en_owner1");
    step(1'b1, 4'b0010, 1'b1, 2'd1, "en_owner1_hold");
    step(1'b0, 4'b0010, 1'b0, 2'd0, "en_low");
    step(1'b1, 4'b0011, 1'b1, 2'd0, "reen_wrap0");
    step(1'b1, 4'b0011, 1'b1, 2'd0, "reen_hold");

    // Asynchronous reset mid-grant, held across an edge, then ptr restarts at 0.
    async_reset("async_rst");
    step(1'b1, 4'b1111, 1'b0, 2'd0, "rst_held");
    #2;
    rst_n = 1'b1;
    step(1'b1, 4'b1001, 1'b1, 2'd0, "ptr0_after_rst");
    step(1'b1, 4'b0000, 1'b0, 2'd0, "post_rst_idle");
    async_reset("async_rst2");
    #2;
    rst_n = 1'b1;

`ifdef RR_ARB_HOLD_TIMEOUT_EN
    // Two requesters alternate every MAX_HOLD cycles.
    for (int k = 0; k < 24; k++) step(1'b1, 4'b0011, 1'b1, 2'((k / 4) % 2), "timeout_alt");
    step(1'b1, 4'b0001, 1'b1, 2'd0, "timeout_release");
    for (int k = 0; k < 20; k++) step(1'b1, 4'b0001, 1'b1, 2'd0, "timeout_saturate");
    // Counter saturated: a newly pending requester wins on the very next edge.
    step(1'b1, 4'b0011, 1'b1, 2'd1, "timeout_sat_rotate");
`else
    // No timeout: owner 0 keeps the grant indefinitely.
    for (int k = 0; k < 55; k++) step(1'b1, 4'b0011, 1'b1, 2'd0, "no_timeout");
    step(1'b1, 4'b0001, 1'b1, 2'd0, "no_timeout_single");
    for (int k = 0; k < 20; k++) step(1'b1, 4'b0001, 1'b1, 2'd0, "no_timeout_single");
    step(1'b1, 4'b0011, 1'b1, 2'd0, "no_timeout_no_rotate");
`endif

    step(1'b1, 4'b0000, 1'b0, 2'd0, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
